four_12_12_st0_input_stage: RTL



---
 rtl/four_12_12_st0_input_stage_pkg.sv | 30 +++
 rtl/four_12_12_skid_buf.sv | 50 +++++
 rtl/four_12_12_st0_input_stage.sv | 105 ++++++++++
 3 files changed

// File: rtl/four_12_12_st0_input_stage_pkg.sv
// Shared types and widths for the four_12_12 stage-0 input staging buffer.
// FOUR_12_12_FRAME_CHECK_EN widens buffer entries to carry the burst marker.
package four_12_12_st0_input_stage_pkg;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;
  localparam int BC_W   = 8;

  typedef logic [DATA_W-1:0] float_24_8;
  typedef logic [LEN_W-1:0]  len_t;

  typedef struct packed {
    logic      last;
    float_24_8 data;
  } skid_ent_t;

`ifdef FOUR_12_12_FRAME_CHECK_EN
  localparam int ENT_W = DATA_W + 1;
`else
  localparam int ENT_W = DATA_W;
`endif

  function automatic len_t pos_next(
    input len_t pos,
    input logic at_end
  );
    return at_end ? '0 : len_t'(pos + len_t'(1));
  endfunction

endpackage

// File: rtl/four_12_12_skid_buf.sv
// Two-entry ready/valid skid buffer; output and ready are both registered
// so no combinational path runs from i_rdy back to i_vld/o_rdy.
module four_12_12_skid_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_data,
  input  logic         i_vld,
  output logic         o_rdy,
  output logic [W-1:0] o_data,
  output logic         o_vld,
  input  logic         i_rdy
);

  logic [1:0]   r_cnt;
  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic         w_push;
  logic         w_pop;

  assign o_rdy  = (r_cnt != 2'd2);
  assign o_vld  = (r_cnt != 2'd0);
  assign o_data = r_head;
  assign w_push = i_vld & o_rdy;
  assign w_pop  = o_vld & i_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 2'd0;
    end else if (w_push & ~w_pop) begin
      r_cnt <= r_cnt + 2'd1;
    end else if (w_pop & ~w_push) begin
      r_cnt <= r_cnt - 2'd1;
    end
  end

  // a pop refills the head from the tail when full, else from the input
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_head <= (r_cnt == 2'd2) ? r_tail : i_data;
    end else if (w_push && r_cnt == 2'd0) begin
      r_head <= i_data;
    end
    if (w_push && !w_pop && r_cnt == 2'd1) begin
      r_tail <= i_data;
    end
  end

endmodule

// File: rtl/four_12_12_st0_input_stage.sv
// Stage-0 input staging: skid buffer plus burst position / first-word logic.
// Optional FOUR_12_12_FRAME_CHECK_EN: store in_last, resync on it, flag framing.
module four_12_12_st0_input_stage
  import four_12_12_st0_input_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [LEN_W-1:0]  load_length,
  output logic [DATA_W-1:0] stage_0_data,
  output logic              stage_0_data_fst,
  output logic              stage_0_data_vld,
  input  logic              stage_0_data_rdy,
  output logic [BC_W-1:0]   burst_count,
  output logic              frame_err
);

  logic [ENT_W-1:0] w_in_ent;
  logic [ENT_W-1:0] w_head_ent;
  logic             w_pop;
  logic             w_at_end;
  len_t             w_end;
  len_t             r_pos;
  len_t             r_len_q;
  logic [BC_W-1:0]  r_burst_count;

`ifdef FOUR_12_12_FRAME_CHECK_EN
  skid_ent_t w_in_s;
  skid_ent_t w_head_s;
  logic      w_head_last;
  logic      r_frame_err;

  assign w_in_s       = '{last: in_last, data: in_data};
  assign w_in_ent     = w_in_s;
  assign w_head_s     = w_head_ent;
  assign stage_0_data = w_head_s.data;
  assign w_head_last  = w_head_s.last;
`else
  logic w_unused_last;

  assign w_unused_last = in_last;
  assign w_in_ent      = in_data;
  assign stage_0_data  = w_head_ent;
`endif

  four_12_12_skid_buf #(
    .W (ENT_W)
  ) u_skid (
    .clk    (clk),
    .reset  (reset),
    .i_data (w_in_ent),
    .i_vld  (in_vld),
    .o_rdy  (in_rdy),
    .o_data (w_head_ent),
    .o_vld  (stage_0_data_vld),
    .i_rdy  (stage_0_data_rdy)
  );

  assign w_pop = stage_0_data_vld & stage_0_data_rdy;

  // the first word of a burst sees the live length; later words the latched one
  assign w_end    = (r_pos == '0) ? load_length : r_len_q;
  assign w_at_end = (r_pos == w_end);

  assign stage_0_data_fst = stage_0_data_vld & (r_pos == '0);
  assign burst_count      = r_burst_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pos         <= '0;
      r_len_q       <= '0;
      r_burst_count <= '0;
    end else if (w_pop) begin
      if (r_pos == '0) begin
        r_len_q <= load_length;
      end
      if (w_at_end) begin
        r_burst_count <= r_burst_count + 8'd1;
      end
`ifdef FOUR_12_12_FRAME_CHECK_EN
      r_pos <= w_head_last ? '0 : pos_next(r_pos, w_at_end);
`else
      r_pos <= pos_next(r_pos, w_at_end);
`endif
    end
  end

`ifdef FOUR_12_12_FRAME_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_pop & (w_head_last ^ w_at_end);
    end
  end

  assign frame_err = r_frame_err;
`else
  assign frame_err = 1'b0;
`endif

endmodule
